// File: rtl/branch_unit_if.sv
// branch_unit_if: decode-side inputs and PC/link/RAS status outputs of the branch unit.
// PC_W and CNT_W must match the connected branch_unit instance.
interface branch_unit_if #(parameter int PC_W = 9, parameter int CNT_W = 8);
    logic br_valid, stall, N, V, Z;
    logic [2:0] opcode, cond;
    logic [1:0] op;
    logic [PC_W-1:0] sximm8, data_out;
    logic [PC_W-1:0] pc, link_pc;
    logic taken, flush, link_we, ras_mispredict, ras_ovf, ras_unf;
    logic [CNT_W-1:0] mispredict_cnt;
    modport master (
        output br_valid, stall, opcode, op, cond, sximm8, data_out, N, V, Z,
        input  pc, taken, flush, link_we, link_pc, ras_mispredict, ras_ovf, ras_unf, mispredict_cnt
    );
    modport slave (
        input  br_valid, stall, opcode, op, cond, sximm8, data_out, N, V, Z,
        output pc, taken, flush, link_we, link_pc, ras_mispredict, ras_ovf, ras_unf, mispredict_cnt
    );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: PC register, branch resolution, link write-back and a check-only return-address stack.
module branch_unit #(
    parameter int PC_W = 9,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input logic clk,
    input logic rst_n,
    branch_unit_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt, link;
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] ptr, ptr_dec;
    logic [CW-1:0] cnt;
    logic [CNT_W-1:0] mcnt;
    logic mis_q, ovf_q, unf_q;
    logic [4:0] oc;
    logic is_br, is_bl, is_bx, is_blx, lt, br_taken, run, taken, link_we;
    logic accept, push, pop, empty, full, miss;
    logic [7:0] cond_tab;
    assign oc = {bus.opcode, bus.op};
    assign is_br = oc == 5'b00100;
    assign is_bl = oc == 5'b01011;
    assign is_bx = oc == 5'b01000;
    assign is_blx = oc == 5'b01010;
    assign lt = bus.N ^ bus.V;
    // Indexed by cond: 7 never, 6 BGT, 5 BGE, 4 BLE, 3 BLT, 2 BNE, 1 BEQ, 0 B
    assign cond_tab = {1'b0, !lt & !bus.Z, !lt, lt | bus.Z, lt, !bus.Z, bus.Z, 1'b1};
    assign br_taken = is_br & cond_tab[bus.cond];
    assign link = pc_q + 1'b1;
    assign pc_nxt = br_taken ? link + bus.sximm8 :
                    is_bl ? pc_q + bus.sximm8 :
                    (is_bx | is_blx) ? bus.data_out : link;
    assign accept = run & bus.br_valid & !bus.stall;
    assign push = accept & (is_bl | is_blx);
    assign pop = accept & is_bx & !empty;
    assign empty = cnt == '0;
    assign full = cnt == CW'(RAS_DEPTH);
    assign ptr_dec = ptr - 1'b1;
    assign miss = ras[ptr_dec] != bus.data_out;
    always_comb begin
        state_nxt = state;
        run = state == RUN;
        taken = bus.br_valid & run & (is_bl | is_bx | is_blx | br_taken);
        link_we = bus.br_valid & run & (is_bl | is_blx);
        state_nxt = bus.stall ? state : (run && taken) ? FLUSH : RUN;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
            ptr <= '0;
            cnt <= '0;
            mcnt <= '0;
            mis_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mis_q <= pop & miss;
            ovf_q <= push & full;
            unf_q <= accept & is_bx & empty;
            if (accept) pc_q <= pc_nxt;
            if (push) begin
                ptr <= ptr + 1'b1;
                if (!full) cnt <= cnt + 1'b1;
            end else if (pop) begin
                ptr <= ptr_dec;
                cnt <= cnt - 1'b1;
                if (miss && !(&mcnt)) mcnt <= mcnt + 1'b1;
            end
        end
    end
    // A full stack wraps onto its oldest entry; occupancy tracking lives in cnt
    always_ff @(posedge clk)
        if (push) ras[ptr] <= link;
    assign bus.pc = pc_q;
    assign bus.taken = taken;
    assign bus.flush = state == FLUSH;
    assign bus.link_we = link_we;
    assign bus.link_pc = link;
    assign bus.ras_mispredict = mis_q;
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
    assign bus.mispredict_cnt = mcnt;
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vectors with hand-computed expectations for branch_unit (PC_W=9, RAS_DEPTH=4, CNT_W=8).
module tb_branch_unit;
    localparam logic [4:0] NB = 5'b00000, BR = 5'b00100, BL = 5'b01011, BX = 5'b01000, BLX = 5'b01010;
    logic clk = 1'b0, rst_n = 1'b0;
    int nvec = 0, nerr = 0;
    always #5 clk = ~clk;
    branch_unit_if #(.PC_W(9), .CNT_W(8)) bus();
    branch_unit #(.PC_W(9), .RAS_DEPTH(4), .CNT_W(8), .RESET_VEC(9'd0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic drv(input logic v, input logic [4:0] oo, input logic [2:0] c,
                       input logic [8:0] off, input logic [8:0] d, input logic [2:0] nvz);
        bus.br_valid = v;
        {bus.opcode, bus.op} = oo;
        bus.cond = c;
        bus.sximm8 = off;
        bus.data_out = d;
        {bus.N, bus.V, bus.Z} = nvz;
        #1;
    endtask
    task automatic idle;
        drv(1'b0, NB, 3'd0, 9'd0, 9'd0, 3'd0);
    endtask
    task automatic jump(input logic [8:0] from, input logic [8:0] to);
        logic [8:0] off;
        off = to - from - 9'd1;
        drv(1'b1, BR, 3'd0, off, 9'd0, 3'd0);
        cyc;
        chk("jump_pc", bus.pc, to);
        idle;
        cyc;
    endtask
    initial begin
        bus.stall = 1'b0;
        idle;
        cyc;
        cyc;
        chk("rst_pc", bus.pc, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_cnt", bus.mispredict_cnt, 0);
        chk("rst_pulses", {bus.ras_mispredict, bus.ras_ovf, bus.ras_unf}, 0);
        rst_n = 1'b1;
        repeat (5) cyc;
        chk("idle_pc", bus.pc, 0);
        for (int i = 1; i <= 3; i++) begin
            drv(1'b1, NB, 3'd0, 9'd7, 9'd0, 3'd0);
            chk("nb_taken", bus.taken, 0);
            cyc;
            chk("nb_pc", bus.pc, i);
        end
        rst_n = 1'b0;
        #2;
        chk("async_rst_pc", bus.pc, 0);
        rst_n = 1'b1;
        idle;
        cyc;
        jump(9'd0, 9'd10);
        drv(1'b1, BR, 3'b011, 9'd5, 9'd0, 3'b100);
        chk("blt_taken", bus.taken, 1);
        chk("blt_link_we", bus.link_we, 0);
        cyc;
        chk("blt_pc", bus.pc, 16);
        chk("blt_flush", bus.flush, 1);
        chk("flush_taken", bus.taken, 0);
        cyc;
        chk("flush_hold_pc", bus.pc, 16);
        chk("flush_done", bus.flush, 0);
        jump(9'd16, 9'd10);
        drv(1'b1, BR, 3'b110, 9'd5, 9'd0, 3'b001);
        chk("bgt_taken", bus.taken, 0);
        cyc;
        chk("bgt_pc", bus.pc, 11);
        chk("bgt_flush", bus.flush, 0);
        drv(1'b1, BR, 3'b101, 9'd2, 9'd0, 3'b110);
        chk("bge_taken", bus.taken, 1);
        cyc;
        chk("bge_pc", bus.pc, 14);
        idle;
        cyc;
        drv(1'b1, BR, 3'b111, 9'd2, 9'd0, 3'b000);
        chk("never_taken", bus.taken, 0);
        cyc;
        chk("never_pc", bus.pc, 15);
        jump(9'd15, 9'd510);
        drv(1'b1, BR, 3'b000, 9'd3, 9'd0, 3'b000);
        cyc;
        chk("wrap_pc", bus.pc, 2);
        idle;
        cyc;
        jump(9'd2, 9'd20);
        drv(1'b1, BL, 3'd0, 9'd30, 9'd0, 3'd0);
        chk("bl_taken", bus.taken, 1);
        chk("bl_link_we", bus.link_we, 1);
        chk("bl_link_pc", bus.link_pc, 21);
        cyc;
        chk("bl_pc", bus.pc, 50);
        idle;
        cyc;
        drv(1'b1, BX, 3'd0, 9'd0, 9'd21, 3'd0);
        chk("bx_taken", bus.taken, 1);
        chk("bx_link_we", bus.link_we, 0);
        cyc;
        chk("ret_pc", bus.pc, 21);
        chk("ret_mis", bus.ras_mispredict, 0);
        chk("ret_cnt", bus.mispredict_cnt, 0);
        idle;
        cyc;
        jump(9'd21, 9'd20);
        drv(1'b1, BL, 3'd0, 9'd30, 9'd0, 3'd0);
        cyc;
        idle;
        cyc;
        drv(1'b1, BX, 3'd0, 9'd0, 9'd40, 3'd0);
        cyc;
        chk("mis_pc", bus.pc, 40);
        chk("mis_pulse", bus.ras_mispredict, 1);
        chk("mis_cnt", bus.mispredict_cnt, 1);
        idle;
        cyc;
        chk("mis_pulse_end", bus.ras_mispredict, 0);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, BL, 3'd0, 9'd2, 9'd0, 3'd0);
            cyc;
            chk("push_pc", bus.pc, 42 + 2 * i);
            chk("push_ovf", bus.ras_ovf, (i == 4) ? 1 : 0);
            idle;
            cyc;
        end
        chk("ovf_end", bus.ras_ovf, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, BX, 3'd0, 9'd0, 9'(49 - 2 * i), 3'd0);
            cyc;
            chk("pop_pc", bus.pc, 49 - 2 * i);
            chk("pop_mis", bus.ras_mispredict, 0);
            chk("pop_unf", bus.ras_unf, 0);
            idle;
            cyc;
        end
        drv(1'b1, BX, 3'd0, 9'd0, 9'd7, 3'd0);
        cyc;
        chk("unf_pc", bus.pc, 7);
        chk("unf_pulse", bus.ras_unf, 1);
        chk("unf_mis", bus.ras_mispredict, 0);
        chk("unf_cnt", bus.mispredict_cnt, 1);
        idle;
        cyc;
        chk("unf_end", bus.ras_unf, 0);
        drv(1'b1, BLX, 3'd0, 9'd0, 9'd100, 3'd0);
        chk("blx_link_we", bus.link_we, 1);
        cyc;
        chk("blx_pc", bus.pc, 100);
        idle;
        cyc;
        drv(1'b1, BX, 3'd0, 9'd0, 9'd8, 3'd0);
        cyc;
        chk("blx_ret_pc", bus.pc, 8);
        chk("blx_ret_mis", bus.ras_mispredict, 0);
        idle;
        cyc;
        bus.stall = 1'b1;
        drv(1'b1, BL, 3'd0, 9'd3, 9'd0, 3'd0);
        chk("stall_taken", bus.taken, 1);
        cyc;
        cyc;
        chk("stall_pc", bus.pc, 8);
        chk("stall_flush", bus.flush, 0);
        bus.stall = 1'b0;
        cyc;
        chk("unstall_pc", bus.pc, 11);
        chk("unstall_flush", bus.flush, 1);
        bus.stall = 1'b1;
        cyc;
        cyc;
        chk("stall_fl_pc", bus.pc, 11);
        chk("stall_fl_flush", bus.flush, 1);
        bus.stall = 1'b0;
        cyc;
        chk("fl_release_pc", bus.pc, 11);
        chk("fl_release_flush", bus.flush, 0);
        drv(1'b1, BX, 3'd0, 9'd0, 9'd9, 3'd0);
        cyc;
        chk("stall_ret_pc", bus.pc, 9);
        chk("stall_ret_mis", bus.ras_mispredict, 0);
        idle;
        cyc;
        drv(1'b1, BX, 3'd0, 9'd0, 9'd0, 3'd0);
        cyc;
        chk("single_push_unf", bus.ras_unf, 1);
        chk("single_push_pc", bus.pc, 0);
        idle;
        cyc;
        for (int k = 1; k <= 300; k++) begin
            drv(1'b1, BL, 3'd0, 9'd0, 9'd0, 3'd0);
            cyc;
            idle;
            cyc;
            drv(1'b1, BX, 3'd0, 9'd0, 9'd0, 3'd0);
            cyc;
            if (k == 200) chk("sat_mid", bus.mispredict_cnt, 201);
            if (k == 253) chk("sat_254", bus.mispredict_cnt, 254);
            if (k == 254) chk("sat_255", bus.mispredict_cnt, 255);
            if (k == 300) chk("sat_mis", bus.ras_mispredict, 1);
            idle;
            cyc;
        end
        chk("sat_final", bus.mispredict_cnt, 255);
        chk("sat_pc", bus.pc, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised successor to the combinational next-PC logic: owns the program counter register and resolves conditional branches, BL/BX/BLX, link-register write-back and return-address tracking.
- Sits between instruction decode and fetch address. Consumes decoded opcode/op/cond, sign-extended offset, register data and N/V/Z flags.
- Adds five things:
  - parametrised width;
  - BGE/BGT conditions;
  - a return-address stack (RAS) with BX mispredict detection;
  - a one-cycle flush state after redirects;
  - a saturating mispredict counter.

Parameters:
- PC_W, 9, width of PC, offset, data and link values
- RAS_DEPTH, 4, RAS entries (power of 2, >=2)
- CNT_W, 8, mispredict counter width
- RESET_VEC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  decoded instruction in opcode/op/cond is resolving this cycle
- stall  in  1  hold PC and all state (except reset)
- opcode  in  3  instruction opcode
- op  in  2  sub-op
- cond  in  3  branch condition
- sximm8  in  PC_W  sign-extended offset
- data_out  in  PC_W  register operand for BX/BLX target
- N, V, Z  in  1 each  status flags
- pc  out  PC_W  current PC (registered)
- taken  out  1  redirect this cycle (combinational)
- flush  out  1  asserted in FLUSH state
- link_we  out  1  write link value this cycle (combinational)
- link_pc  out  PC_W  pc+1
- ras_mispredict  out  1  registered pulse
- ras_ovf  out  1  registered pulse
- ras_unf  out  1  registered pulse
- mispredict_cnt  out  CNT_W  saturating count

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - pc=RESET_VEC;
  - state=RUN;
  - RAS empty, pointer 0;
  - mispredict_cnt=0;
  - all pulses 0.
- Reset mid-operation overrides everything immediately.
- Decoding uses {opcode,op}:
  - Br=00100
  - BL=01011
  - BX=01000
  - BLX=01010
  - any other value is non-branch.
- Branch conditions (Br only; cond value, mnemonic, condition):
  - 000 B: always
  - 001 BEQ: Z
  - 010 BNE: !Z
  - 011 BLT: N!=V
  - 100 BLE: (N!=V)|Z
  - 101 BGE: N==V
  - 110 BGT: (N==V)&!Z
  - 111: never (treated as non-branch)
- Next PC, all arithmetic modulo 2^PC_W (wrap, no flag):
  - Br taken: pc+1+sximm8
  - BL: pc+sximm8
  - BX/BLX: data_out
  - otherwise: pc+1
- taken: br_valid & state==RUN & (BL|BX|BLX|Br-taken).
- link_we: br_valid & state==RUN & (BL|BLX). link_pc is always pc+1.
- FSM states:
  - RUN: if !stall and br_valid, pc<=next PC. If taken, go to FLUSH. A non-branch instruction just advances pc by 1.
  - FLUSH: flush=1 for exactly one non-stalled cycle. br_valid is ignored, pc holds, no RAS action. Then return to RUN.
- Stall: when stall=1 in either state, the state, pc, RAS and counter hold. taken/link_we still reflect inputs combinationally, but have no registered effect.
- RAS actions occur only on an accepted instruction (RUN, br_valid, !stall):
  - BL/BLX: push pc+1.
  - Push when full: overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_ovf=1 next cycle.
  - BX when non-empty: pop. If the popped value != data_out, set ras_mispredict=1 next cycle and increment mispredict_cnt, saturating at all-ones.
  - BX when empty: no pop, ras_unf=1 next cycle, no mispredict.
- The BX target is always data_out. The RAS is check-only and never redirects.
- Pulse outputs last one cycle and are 0 otherwise.

Test Plan:
- Reset then run: 5 cycles with br_valid=0 → pc stays 0. br_valid=1 with non-branch encoding for 3 cycles → pc 1,2,3. Assert rst_n=0 mid-cycle → pc=0 immediately.
- Conditional branch taken: pc=10, Br BLT, N=1, V=0, sximm8=5 → taken=1, pc=16 next cycle, flush=1 the following cycle with pc held at 16, then RUN. Same setup with BGT, N=V=0, Z=1 → not taken, pc=11.
- Wrap-around: PC_W=9, pc=510, Br B, sximm8=3 → pc=2.
- Call/return: pc=20, BL sximm8=30 → link_we=1, link_pc=21, pc=50. After flush, BX data_out=21 → pc=21, no mispredict. Repeat with data_out=40 → ras_mispredict pulse, mispredict_cnt=1.
- RAS boundaries: 5 BLs with RAS_DEPTH=4 → ras_ovf on the 5th. 4 BXs with matching data succeed. A 5th BX → ras_unf=1, cnt unchanged, pc=data_out.
- Stall during FLUSH and during a BL: pc, state and RAS unchanged while stall=1. Release stall → the single flush cycle and the push occur once. mispredict_cnt saturates at 255 after 300 mispredicts.
